// File: rtl/rbi_mem_l1_req_if.sv
// rbi_mem_l1_req_if: ring hop plus core request port of the ring-bus initiator node.
interface rbi_mem_l1_req_if;
    logic [47:0]  memAddrIn;
    logic [127:0] memDataIn;
    logic [15:0]  memOpmIn;
    logic [15:0]  memSeqIn;
    logic [47:0]  memAddrOut;
    logic [127:0] memDataOut;
    logic [15:0]  memOpmOut;
    logic [15:0]  memSeqOut;
    logic [7:0]   unitNodeId;
    logic [1:0]   reqOpm;
    logic [47:0]  reqAddr;
    logic [127:0] reqData;
    logic [1:0]   respOK;
    logic [127:0] respData;

    modport slave (
        input  memAddrIn, memDataIn, memOpmIn, memSeqIn, unitNodeId, reqOpm, reqAddr, reqData,
        output memAddrOut, memDataOut, memOpmOut, memSeqOut, respOK, respData
    );
    modport master (
        output memAddrIn, memDataIn, memOpmIn, memSeqIn, unitNodeId, reqOpm, reqAddr, reqData,
        input  memAddrOut, memDataOut, memOpmOut, memSeqOut, respOK, respData
    );
endinterface

// File: rtl/rbi_mem_l1_req.sv
// rbi_mem_l1_req: ring-bus initiator node injecting one LDX/STX and retiring its response.
// Define RBI_L1REQ_RETRY_EN to re-inject lost requests up to RETRY_MAX times before faulting.
module rbi_mem_l1_req #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [7:0]  OPM_LDX     = 8'h90,
    parameter logic [7:0]  OPM_STX     = 8'hA0,
    parameter logic [7:0]  OPM_FLT     = 8'h7F,
    parameter int unsigned RETRY_MAX   = 2
) (
    input logic clock,
    input logic reset,
    rbi_mem_l1_req_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INJECT = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [7:0]   seq_q, seq_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [47:0]  lat_addr_q, lat_addr_d;
    logic [127:0] lat_data_q, lat_data_d;
    logic         lat_st_q, lat_st_d;
    logic [127:0] rdata_q, rdata_d;
    logic [47:0]  addr_o_q, addr_o_d;
    logic [127:0] data_o_q, data_o_d;
    logic [15:0]  opm_o_q, opm_o_d;
    logic [15:0]  seq_o_q, seq_o_d;
    logic [7:0]   retry_q;
`ifdef RBI_L1REQ_RETRY_EN
    logic [7:0]   retry_d;
`else
    // Without retries the budget starts out exhausted, so every loss faults.
    assign retry_q = 8'(RETRY_MAX);
`endif

    logic own, is_resp, match, free, inject, give_up, lost;
    logic [7:0] seq_inc;

    assign own     = bus.memSeqIn[15:8] == bus.unitNodeId && bus.memOpmIn[7:0] != 8'h00;
    assign is_resp = bus.memOpmIn[7:6] == 2'b01;
    assign match   = own && bus.memSeqIn[7:0] == seq_q && state_q == WAIT;
    // Every owned slot leaves the ring here: current results, stale copies and unanswered requests.
    assign free    = bus.memOpmIn[7:0] == 8'h00 || own;
    assign inject  = state_q == INJECT && free;
    assign give_up = retry_q >= 8'(RETRY_MAX);
    assign lost    = (match && !is_resp) || timer_q == TW'(TIMEOUT_CYC - 1);
    assign seq_inc = seq_q == 8'hFF ? 8'h01 : seq_q + 8'h01;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        timer_d    = timer_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        lat_st_d   = lat_st_q;
        rdata_d    = rdata_q;
`ifdef RBI_L1REQ_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef RBI_L1REQ_RETRY_EN
                retry_d = 8'h00;
`endif
                if (bus.reqOpm == 2'd1 || bus.reqOpm == 2'd2) begin
                    lat_addr_d = bus.reqAddr;
                    lat_st_d   = bus.reqOpm == 2'd2;
                    lat_data_d = bus.reqOpm == 2'd2 ? bus.reqData : 128'h0;
                    state_d    = INJECT;
                end
            end
            INJECT: if (free) begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (match && is_resp && bus.memOpmIn[7:0] != OPM_FLT) begin
                    rdata_d = lat_st_q ? 128'h0 : bus.memDataIn;
                    state_d = DONE;
                end else if ((match && is_resp) || (lost && give_up)) begin
                    rdata_d = 128'h0;
                    state_d = FAULT;
                end else if (lost) begin
`ifdef RBI_L1REQ_RETRY_EN
                    retry_d = retry_q + 8'h01;
`endif
                    seq_d   = seq_inc;
                    state_d = INJECT;
                end
            end
            default: if (bus.reqOpm == 2'd0) begin
                seq_d   = seq_inc;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        opm_o_d  = inject ? {8'h00, lat_st_q ? OPM_STX : OPM_LDX} : free ? 16'h0 : bus.memOpmIn;
        seq_o_d  = inject ? {bus.unitNodeId, seq_q} : free ? 16'h0 : bus.memSeqIn;
        addr_o_d = inject ? lat_addr_q : free ? 48'h0 : bus.memAddrIn;
        data_o_d = inject ? lat_data_q : free ? 128'h0 : bus.memDataIn;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            seq_q      <= 8'h01;
            timer_q    <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_st_q   <= 1'b0;
            rdata_q    <= '0;
            addr_o_q   <= '0;
            data_o_q   <= '0;
            opm_o_q    <= '0;
            seq_o_q    <= '0;
`ifdef RBI_L1REQ_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            timer_q    <= timer_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_st_q   <= lat_st_d;
            rdata_q    <= rdata_d;
            addr_o_q   <= addr_o_d;
            data_o_q   <= data_o_d;
            opm_o_q    <= opm_o_d;
            seq_o_q    <= seq_o_d;
`ifdef RBI_L1REQ_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign bus.memAddrOut = addr_o_q;
    assign bus.memDataOut = data_o_q;
    assign bus.memOpmOut  = opm_o_q;
    assign bus.memSeqOut  = seq_o_q;
    assign bus.respData   = rdata_q;
    assign bus.respOK     = state_q == IDLE ? 2'd0 : state_q == DONE ? 2'd1 :
                            state_q == FAULT ? 2'd3 : 2'd2;
endmodule

// File: tb/tb_rbi_mem_l1_req.sv
// tb_rbi_mem_l1_req: directed vectors for the ring-bus initiator node.
module tb_rbi_mem_l1_req;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] sq;

    rbi_mem_l1_req_if bus ();
    rbi_mem_l1_req dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [15:0] opm, input logic [15:0] seq,
                          input logic [47:0] addr, input logic [127:0] data);
        bus.memOpmIn  = opm;
        bus.memSeqIn  = seq;
        bus.memAddrIn = addr;
        bus.memDataIn = data;
    endtask

    initial begin
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.unitNodeId = 8'h10;
        bus.reqOpm     = 2'd0;
        bus.reqAddr    = 48'h0;
        bus.reqData    = 128'h0;
        sq = 8'h01;
        tick();
        tick();
        check("rst_opm", 128'(bus.memOpmOut), 128'h0);
        check("rst_resp", 128'(bus.respOK), 128'h0);
        check("rst_data", bus.respData, 128'h0);
        reset = 1'b1;

        // Foreign slot is forwarded unchanged one cycle later
        set_in(16'h0090, 16'h8201, 48'h1000, 128'h55);
        tick();
        check("pt_opm", 128'(bus.memOpmOut), 128'h0090);
        check("pt_seq", 128'(bus.memSeqOut), 128'h8201);
        check("pt_addr", 128'(bus.memAddrOut), 128'h1000);
        check("pt_data", bus.memDataOut, 128'h55);
        check("pt_resp", 128'(bus.respOK), 128'h0);

        // Load success
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.reqOpm  = 2'd1;
        bus.reqAddr = 48'h0000_2000;
        tick();
        check("ld_hold", 128'(bus.respOK), 128'h2);
        tick();
        check("ld_inj_opm", 128'(bus.memOpmOut), 128'h0090);
        check("ld_inj_seq", 128'(bus.memSeqOut), 128'h1001);
        check("ld_inj_addr", 128'(bus.memAddrOut), 128'h2000);
        check("ld_inj_data", bus.memDataOut, 128'h0);
        set_in(16'h0050, 16'h1001, 48'h2000, 128'hDEADBEEF);
        tick();
        check("ld_ok", 128'(bus.respOK), 128'h1);
        check("ld_rdata", bus.respData, 128'hDEADBEEF);
        check("ld_consumed", 128'(bus.memOpmOut), 128'h0);
        check("ld_consumed_d", bus.memDataOut, 128'h0);
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.reqOpm = 2'd0;
        tick();
        sq = 8'h02;
        check("ld_idle", 128'(bus.respOK), 128'h0);

        // No responder: our own request comes back unanswered
        bus.reqOpm = 2'd1;
        tick();
        tick();
        check("nr_inj_seq", 128'(bus.memSeqOut), 128'h1002);
        check("nr_inj_opm", 128'(bus.memOpmOut), 128'h0090);
        set_in(16'h0090, 16'h1002, 48'h2000, 128'h0);
        tick();
        check("nr_consumed", 128'(bus.memOpmOut), 128'h0);
`ifdef RBI_L1REQ_RETRY_EN
        check("nr_retry", 128'(bus.respOK), 128'h2);
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        sq = 8'h03;
        tick();
        check("nr_reinj_seq", 128'(bus.memSeqOut), 128'h1003);
        set_in(16'h0050, 16'h1003, 48'h0, 128'h77);
        tick();
        check("nr_retry_ok", 128'(bus.respOK), 128'h1);
`else
        check("nr_fault", 128'(bus.respOK), 128'h3);
        check("nr_rdata", bus.respData, 128'h0);
`endif
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.reqOpm = 2'd0;
        tick();
        sq = sq + 8'h01;
        check("nr_idle", 128'(bus.respOK), 128'h0);

        // Store against a full ring: 20 occupied foreign slots stall injection
        bus.reqOpm  = 2'd2;
        bus.reqAddr = 48'h3000;
        bus.reqData = 128'hCAFE;
        for (int i = 0; i < 20; i++) begin
            set_in(16'h00A0, 16'h2200 + 16'(i), 48'h4000 + 48'(i), 128'(i));
            tick();
            check("fr_pass_seq", 128'(bus.memSeqOut), 128'(16'h2200 + 16'(i)));
            check("fr_hold", 128'(bus.respOK), 128'h2);
        end
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        tick();
        check("st_inj_opm", 128'(bus.memOpmOut), 128'h00A0);
        check("st_inj_seq", 128'(bus.memSeqOut), 128'({8'h10, sq}));
        check("st_inj_addr", 128'(bus.memAddrOut), 128'h3000);
        check("st_inj_data", bus.memDataOut, 128'hCAFE);
        set_in(16'h0050, {8'h10, sq}, 48'h0, 128'h1234);
        tick();
        check("st_ok", 128'(bus.respOK), 128'h1);
        check("st_rdata", bus.respData, 128'h0);
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.reqOpm = 2'd0;
        tick();
        sq = sq + 8'h01;

        // Timeout: nothing returns
        bus.reqOpm  = 2'd1;
        bus.reqAddr = 48'h5000;
        tick();
        tick();
`ifdef RBI_L1REQ_RETRY_EN
        repeat (4096 * 3 + 2 - 1) tick();
        sq = sq + 8'h02;
`else
        repeat (4096 - 1) tick();
`endif
        check("to_edge", 128'(bus.respOK), 128'h2);
        tick();
        check("to_fault", 128'(bus.respOK), 128'h3);
        check("to_rdata", bus.respData, 128'h0);
        bus.reqOpm = 2'd0;
        tick();
        sq = sq + 8'h01;
        check("to_idle", 128'(bus.respOK), 128'h0);
        set_in(16'h0050, {8'h10, sq - 8'h01}, 48'h0, 128'hBEEF);
        tick();
        check("stale_consumed", 128'(bus.memOpmOut), 128'h0);
        check("stale_resp", 128'(bus.respOK), 128'h0);

        // Asynchronous reset while waiting
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        bus.reqOpm = 2'd1;
        tick();
        tick();
        set_in(16'h0090, 16'h8201, 48'h1000, 128'h1);
        tick();
        check("rw_pre", 128'(bus.memSeqOut), 128'h8201);
        #2;
        reset = 1'b0;
        #1;
        check("rw_opm", 128'(bus.memOpmOut), 128'h0);
        check("rw_seq", 128'(bus.memSeqOut), 128'h0);
        check("rw_addr", 128'(bus.memAddrOut), 128'h0);
        check("rw_data", bus.memDataOut, 128'h0);
        check("rw_resp", 128'(bus.respOK), 128'h0);
        set_in(16'h0, 16'h0, 48'h0, 128'h0);
        tick();
        reset = 1'b1;
        tick();
        check("rw_req", 128'(bus.respOK), 128'h2);
        tick();
        check("rw_inj_seq", 128'(bus.memSeqOut), 128'h1001);
        bus.reqOpm = 2'd0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rbi_mem_l1_req.md
Name: rbi_mem_l1_req

Overview:
- Ring-bus initiator node, the requesting end of the ring protocol served by the L2 responder nodes (DDR cache, ROM, MMIO).
- Sits between a core-side single-request memory port and one ring hop.
- Forwards foreign ring traffic with a one-cycle registered hop.
- Injects one LDX/STX request into an empty slot, tracks it by sequence number, and removes the matching response (or a fault) from the ring.

Parameters:
- TIMEOUT_CYC, 4096: cycles spent in WAIT before the request is declared lost.
- OPM_LDX, 8'h90: ring load-request opcode (value of JX2_RBI_OPM_LDX).
- OPM_STX, 8'hA0: ring store-request opcode (value of JX2_RBI_OPM_STX).
- OPM_FLT, 8'h7F: ring fault-response opcode. Any other memOpmIn[7:6]==2'b01 value is a success response.
- RETRY_MAX, 2: re-injections allowed when the optional feature is enabled.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- memAddrIn  in  48  ring address from the upstream hop.
- memDataIn  in  128  ring data tile from the upstream hop.
- memOpmIn  in  16  ring opcode from the upstream hop; [7:0]==0 means an empty slot.
- memSeqIn  in  16  ring sequence: {node id[15:8], counter[7:0]}.
- memAddrOut  out  48  ring address to the downstream hop.
- memDataOut  out  128  ring data tile to the downstream hop.
- memOpmOut  out  16  ring opcode to the downstream hop.
- memSeqOut  out  16  ring sequence to the downstream hop.
- unitNodeId  in  8  this node's id.
- reqOpm  in  2  core request: 0 none, 1 load, 2 store, 3 reserved (treated as none).
- reqAddr  in  48  core request address.
- reqData  in  128  core store data.
- respOK  out  2  0 READY, 1 OK, 2 HOLD, 3 FAULT.
- respData  out  128  load result, valid while respOK==1.

Behaviour:
- Reset (reset low, asynchronous): all mem*Out = 0, respOK = 0, respData = 0, seqCtr = 1, state = IDLE, timer = 0. Ring state is discarded; any in-flight request is forgotten, and a late response for it is dropped as stale.
- Ring hop: every cycle, all mem*Out <= the selected slot (pass-through, injection, or empty). Latency is exactly 1 cycle.
- Ownership: a slot is "ours" when memSeqIn[15:8]==unitNodeId and memOpmIn[7:0]!=0.
- Owned responses (memOpmIn[7:6]==2'b01), in any state:
  - seq[7:0]==seqCtr and state==WAIT: consume it (output an empty slot, all fields zero) and capture the result.
  - Otherwise the response is stale: consume it silently.
- Owned request returning with seq[7:0]==seqCtr while in WAIT: no responder exists. Consume it and go to FAULT.
- IDLE:
  - respOK = 0.
  - reqOpm in {1,2}: latch addr/data/opcode, respOK = 2, go to INJECT.
- INJECT:
  - respOK = 2.
  - Injection happens when the incoming slot is empty or is being consumed this cycle.
  - Injected slot: Opm = {8'h00, OPM_LDX or OPM_STX}, Seq = {unitNodeId, seqCtr}, Addr = latched address, Data = latched data (zero for loads).
  - Go to WAIT with timer cleared.
  - Occupied foreign slots pass through untouched; a full ring stalls INJECT indefinitely.
- WAIT:
  - respOK = 2; timer increments each cycle.
  - Matching success: respData <= memDataIn for loads, 0 for stores; go to DONE.
  - Matching OPM_FLT, or timer == TIMEOUT_CYC-1: go to FAULT.
- DONE: respOK = 1; hold until reqOpm==0, then increment seqCtr and go to IDLE.
- FAULT: respOK = 3, respData = 0; hold until reqOpm==0, then increment seqCtr and go to IDLE.
- seqCtr wraps 255 -> 1; the value 0 is never issued.
- reqOpm changes while busy are ignored; the latched request stands.
- Simultaneous matching response and timeout expiry: the response wins.

Optional Feature:
- Macro: RBI_L1REQ_RETRY_EN.
- Defined:
  - A timeout or no-responder event with retries < RETRY_MAX increments the retry count, bumps seqCtr (so the old copy becomes stale), and returns to INJECT.
  - FAULT is entered only when retries are exhausted.
  - The retry count clears in IDLE.
- Undefined: the first timeout or no-responder event goes directly to FAULT.

Test Plan:
- Idle pass-through: foreign slot Opm=0x0090, Seq=0x8201, Addr=0x1000 at cycle N -> identical fields on the outputs at N+1; respOK stays 0.
- Load success:
  - Stimulus: unitNodeId=0x10, reqOpm=1, Addr=0x0000_2000, ring empty.
  - Injection: out Opm=0x90, Seq=0x1001 one cycle after INJECT.
  - Response: feed back Opm=0x50, Seq=0x1001, Data=0xDEADBEEF.
  - Required: respOK=1, respData=0xDEADBEEF; that slot leaves the ring empty; after reqOpm drops to 0, the next injection uses Seq=0x1002.
- Full ring:
  - Stimulus: 20 consecutive occupied foreign slots.
  - Required: no injection during those cycles; injection on the first empty slot; respOK=2 throughout.
- No responder: own request Seq=0x1001, Opm=0x90 returns unanswered -> slot consumed; respOK=3 (or re-injected with Seq=0x1002 when RBI_L1REQ_RETRY_EN is defined).
- Timeout plus stale response:
  - Stimulus: nothing returns for 4096 cycles.
  - Required: respOK=3.
  - Follow-up: a later Opm=0x50, Seq=0x1001 arrives in IDLE -> consumed, respOK stays 0.
- Reset in WAIT: reset low mid-WAIT -> all outputs 0 immediately; after release, state is IDLE and the next request uses Seq counter 1.
